fetch_unit: RTL and testbench

Instruction fetch stage for the 8-bit processor. Owns the program counter, drives the instruction memory address, and captures the returned instruction into a registered output slot with a valid/ready handshake toward decode. It resolves the unconditional jump (`j`) locally so that decode only ever sees the correct instruction stream. A jump to itself parks the stage in a halted state.

---
 rtl/fetch_unit.sv | 77 +++++++
 tb/tb_fetch_unit.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, resolves unconditional jumps locally and
// presents one registered instruction slot to decode under a valid/ready handshake.
module fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter int                INST_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
  input  logic              Clock,
  input  logic              Reset,
  output logic [ADDR_W-1:0] Address,
  input  logic [INST_W-1:0] Instruction,
  output logic [INST_W-1:0] Out_Instr,
  output logic [ADDR_W-1:0] Out_PC,
  output logic              Out_IsJump,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic              Halted
);

  typedef enum logic [1:0] {WARMUP, RUN, HALT} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_inc, pc_nxt;
  logic              free, is_j, self_j, fetch;

  assign Address = pc;
  assign free    = !Out_Valid || Out_Ready;
  assign is_j    = (Instruction[7:6] == 2'b11);
  assign self_j  = is_j && (Instruction[5:0] == 6'h3F);
  assign pc_inc  = pc + ADDR_W'(1);
  // A self-jump needs no special case: PC + 1 - 1 leaves the PC where it is.
  assign pc_nxt  = is_j ? pc_inc + {{(ADDR_W-6){Instruction[5]}}, Instruction[5:0]}
                        : pc_inc;

  // State register
  always_ff @(posedge Clock) begin
    if (!Reset) state <= WARMUP;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      WARMUP:  state_nxt = RUN;
      RUN:     if (free && self_j) state_nxt = HALT;
      HALT:    state_nxt = HALT;
      default: state_nxt = WARMUP;
    endcase
  end

  // Output / control decode
  always_comb begin
    fetch  = (state == RUN) && free;
    Halted = (state == HALT);
  end

  // Datapath: PC and the output slot. Accept and refill share one edge.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      pc         <= RESET_PC;
      Out_Instr  <= '0;
      Out_PC     <= '0;
      Out_IsJump <= 1'b0;
      Out_Valid  <= 1'b0;
    end else if (fetch) begin
      pc         <= pc_nxt;
      Out_Instr  <= Instruction;
      Out_PC     <= pc;
      Out_IsJump <= is_j;
      Out_Valid  <= 1'b1;
    end else if (Out_Valid && Out_Ready) begin
      Out_Valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table on a RESET_PC=0 instance,
// plus a hand sequence on a RESET_PC=FE instance for wrap-around and backward jump.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst, rdy;
  logic [7:0] addr, instr, o_ins, o_pc;
  logic       o_j, o_v, hlt;

  logic       rst2, rdy2;
  logic [7:0] addr2, instr2, o_ins2, o_pc2;
  logic       o_j2, o_v2, hlt2;

  logic [7:0] mem  [256];
  logic [7:0] mem2 [256];

  int errors = 0;
  int checks = 0;
  logic seen4 = 1'b0;

  always #5 clk = ~clk;

  assign instr  = mem[addr];
  assign instr2 = mem2[addr2];

  fetch_unit #(.ADDR_W(8), .INST_W(8), .RESET_PC(8'h00)) u_dut (
    .Clock(clk), .Reset(rst), .Address(addr), .Instruction(instr),
    .Out_Instr(o_ins), .Out_PC(o_pc), .Out_IsJump(o_j), .Out_Valid(o_v),
    .Out_Ready(rdy), .Halted(hlt)
  );

  fetch_unit #(.ADDR_W(8), .INST_W(8), .RESET_PC(8'hFE)) u_wrap (
    .Clock(clk), .Reset(rst2), .Address(addr2), .Instruction(instr2),
    .Out_Instr(o_ins2), .Out_PC(o_pc2), .Out_IsJump(o_j2), .Out_Valid(o_v2),
    .Out_Ready(rdy2), .Halted(hlt2)
  );

  // The jump at 3 skips address 4, in every stream this bench runs.
  always @(negedge clk) if (rst && addr == 8'd4) seen4 = 1'b1;

  typedef struct {
    logic       rst, rdy;
    logic       val;
    logic [7:0] pc, ins;
    logic       jmp, hlt;
    logic [7:0] addr;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t v(logic r, logic rd, logic vl, logic [7:0] p, logic [7:0] i,
                             logic j, logic h, logic [7:0] a);
    vec_t t;
    t.rst = r; t.rdy = rd; t.val = vl; t.pc = p; t.ins = i;
    t.jmp = j; t.hlt = h; t.addr = a;
    return t;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    foreach (mem[i])  mem[i]  = 8'h00;
    foreach (mem2[i]) mem2[i] = 8'h00;
    mem[0] = 8'h27; mem[1] = 8'h61; mem[2] = 8'h3C; mem[3] = 8'hC1;
    mem[4] = 8'h7B; mem[5] = 8'h0F; mem[6] = 8'hFF;
    mem2[8'hFE] = 8'h05; mem2[8'hFF] = 8'h12; mem2[8'h00] = 8'h20;
    mem2[8'h01] = 8'h33; mem2[8'h02] = 8'hFC;

    // Straight line with jump and self-jump halt
    tv.push_back(v(0,1, 0,8'h00,8'h00,0,0,8'h00));
    tv.push_back(v(1,1, 0,8'h00,8'h00,0,0,8'h00));
    tv.push_back(v(1,1, 0,8'h00,8'h00,0,0,8'h00));
    tv.push_back(v(1,1, 1,8'h00,8'h27,0,0,8'h01));
    tv.push_back(v(1,1, 1,8'h01,8'h61,0,0,8'h02));
    tv.push_back(v(1,1, 1,8'h02,8'h3C,0,0,8'h03));
    tv.push_back(v(1,1, 1,8'h03,8'hC1,1,0,8'h05));
    tv.push_back(v(1,1, 1,8'h05,8'h0F,0,0,8'h06));
    tv.push_back(v(1,1, 1,8'h06,8'hFF,1,1,8'h06));
    tv.push_back(v(1,1, 0,8'h06,8'hFF,1,1,8'h06));
    tv.push_back(v(1,1, 0,8'h06,8'hFF,1,1,8'h06));
    // Reset out of HALT, then backpressure in cycles 3-5
    tv.push_back(v(0,1, 0,8'h06,8'hFF,1,1,8'h06));
    tv.push_back(v(1,1, 0,8'h00,8'h00,0,0,8'h00));
    tv.push_back(v(1,1, 0,8'h00,8'h00,0,0,8'h00));
    tv.push_back(v(1,1, 1,8'h00,8'h27,0,0,8'h01));
    tv.push_back(v(1,0, 1,8'h01,8'h61,0,0,8'h02));
    tv.push_back(v(1,0, 1,8'h01,8'h61,0,0,8'h02));
    tv.push_back(v(1,0, 1,8'h01,8'h61,0,0,8'h02));
    tv.push_back(v(1,1, 1,8'h01,8'h61,0,0,8'h02));
    tv.push_back(v(1,1, 1,8'h02,8'h3C,0,0,8'h03));
    tv.push_back(v(1,1, 1,8'h03,8'hC1,1,0,8'h05));
    tv.push_back(v(1,0, 1,8'h05,8'h0F,0,0,8'h06));
    // Reset while stalled with a valid slot; slot is discarded
    tv.push_back(v(0,0, 1,8'h05,8'h0F,0,0,8'h06));
    tv.push_back(v(1,0, 0,8'h00,8'h00,0,0,8'h00));
    tv.push_back(v(1,0, 0,8'h00,8'h00,0,0,8'h00));
    tv.push_back(v(1,0, 1,8'h00,8'h27,0,0,8'h01));
    tv.push_back(v(1,1, 1,8'h00,8'h27,0,0,8'h01));
    tv.push_back(v(1,1, 1,8'h01,8'h61,0,0,8'h02));

    rst = 1'b0; rdy = 1'b1; rst2 = 1'b0; rdy2 = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < tv.size(); i++) begin
      #1;
      rst = tv[i].rst;
      rdy = tv[i].rdy;
      @(negedge clk);
      check($sformatf("vec%0d {val,pc,ins,jmp,hlt,addr}", i),
            64'({o_v, o_pc, o_ins, o_j, hlt, addr}),
            64'({tv[i].val, tv[i].pc, tv[i].ins, tv[i].jmp, tv[i].hlt, tv[i].addr}));
      @(posedge clk);
    end
    check("addr4_never_fetched", 64'(seen4), 64'(0));

    // Wrap-around from RESET_PC=FE and backward jump at 02 -> FF
    begin
      logic [7:0] e_pc  [9] = '{8'h00, 8'h00, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'hFF, 8'h00};
      logic [7:0] e_ins [9] = '{8'h00, 8'h00, 8'h05, 8'h12, 8'h20, 8'h33, 8'hFC, 8'h12, 8'h20};
      logic [7:0] e_adr [9] = '{8'hFE, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'hFF, 8'h00, 8'h01};
      logic       e_v   [9] = '{0, 0, 1, 1, 1, 1, 1, 1, 1};
      logic       e_j   [9] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
      #1 rst2 = 1'b1;
      for (int k = 0; k < 9; k++) begin
        @(negedge clk);
        check($sformatf("wrap%0d {val,pc,ins,jmp,hlt,addr}", k),
              64'({o_v2, o_pc2, o_ins2, o_j2, hlt2, addr2}),
              64'({e_v[k], e_pc[k], e_ins[k], e_j[k], 1'b0, e_adr[k]}));
        @(posedge clk);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
